// File: rtl/clock_divider_multi_if.sv
// Divisor configuration bus for clock_divider_multi.
// Request/ready handshake plus a registered reject pulse.
interface clock_divider_multi_if #(
    parameter int N_CH      = 4,
    parameter int DIV_WIDTH = 16
) ();
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                 cfg_valid;
    logic [CW-1:0]        cfg_ch;
    logic [DIV_WIDTH-1:0] cfg_div;
    logic                 cfg_ready;
    logic                 cfg_err;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_div,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_div,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/clock_divider_multi.sv
// N_CH independent clock dividers with glitch-free divisor updates.
// Pending divisors are applied only at a period boundary.
module clock_divider_multi #(
    parameter int N_CH        = 4,
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 10
) (
    input  logic            clk_in,
    input  logic            reset,
    input  logic [N_CH-1:0] enable,
    input  logic            sync,
    clock_divider_multi_if.slave cfg,
    output logic [N_CH-1:0] clk_out,
    output logic [N_CH-1:0] tick
);
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef logic [DIV_WIDTH-1:0] div_t;

    localparam div_t DEF_DIV = div_t'(DEFAULT_DIV);
    localparam div_t ONE     = div_t'(1);
    localparam div_t TWO     = div_t'(2);

    div_t div_q  [N_CH];
    div_t div_n  [N_CH];
    div_t cnt_q  [N_CH];
    div_t cnt_n  [N_CH];
    div_t pdiv_q [N_CH];
    div_t pdiv_n [N_CH];

    logic [N_CH-1:0] pend_q;
    logic [N_CH-1:0] pend_n;
    logic [N_CH-1:0] clk_q;
    logic [N_CH-1:0] clk_n;
    logic [N_CH-1:0] tick_q;
    logic [N_CH-1:0] tick_n;
    logic [N_CH-1:0] sel;
    logic [N_CH-1:0] load;
    logic [N_CH-1:0] restart;

    logic ready;
    logic take;
    logic bad;
    logic err_q;

    // An out-of-range channel selects nothing, so it reads as ready.
    always_comb begin
        sel = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (cfg.cfg_ch == CW'(i)) sel[i] = 1'b1;
        end
        ready = ~|(sel & pend_q);
        take  = cfg.cfg_valid && ready;
        bad   = take && (~|sel || cfg.cfg_div < TWO);
        load  = (take && !bad) ? sel : '0;
    end

    always_comb begin
        div_n   = div_q;
        cnt_n   = cnt_q;
        pdiv_n  = pdiv_q;
        pend_n  = pend_q;
        clk_n   = '0;
        tick_n  = '0;
        restart = '0;
        for (int i = 0; i < N_CH; i++) begin
            restart[i] = enable[i] &&
                         (sync || cnt_q[i] == div_q[i] - ONE);
            unique case (1'b1)
                !enable[i]: begin
                    if (pend_q[i]) begin
                        div_n[i]  = pdiv_q[i];
                        pend_n[i] = 1'b0;
                    end
                    cnt_n[i] = div_n[i] - ONE;
                end
                restart[i]: begin
                    if (pend_q[i]) begin
                        div_n[i]  = pdiv_q[i];
                        pend_n[i] = 1'b0;
                    end
                    cnt_n[i] = '0;
                end
                default: cnt_n[i] = cnt_q[i] + ONE;
            endcase
            if (enable[i]) begin
                tick_n[i] = (cnt_n[i] == '0);
                clk_n[i]  = cnt_n[i] <
                            (div_n[i] - (div_n[i] >> 1));
            end
            // Loading needs pend_q==0, so it never races an apply.
            if (load[i]) begin
                pdiv_n[i] = cfg.cfg_div;
                pend_n[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                div_q[i]  <= DEF_DIV;
                cnt_q[i]  <= DEF_DIV - ONE;
                pdiv_q[i] <= DEF_DIV;
            end
            pend_q <= '0;
            clk_q  <= '0;
            tick_q <= '0;
            err_q  <= 1'b0;
        end else begin
            div_q  <= div_n;
            cnt_q  <= cnt_n;
            pdiv_q <= pdiv_n;
            pend_q <= pend_n;
            clk_q  <= clk_n;
            tick_q <= tick_n;
            err_q  <= bad;
        end
    end

    assign cfg.cfg_ready = ready;
    assign cfg.cfg_err   = err_q;
    assign clk_out       = clk_q;
    assign tick          = tick_q;
endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi.
// Second 3-channel instance exercises an out-of-range channel.
module tb_clock_divider_multi;
    logic       clk_in = 1'b0;
    logic       reset;
    logic [3:0] enable;
    logic       sync;
    logic [3:0] clk_out;
    logic [3:0] tick;
    logic [2:0] enable_b;
    logic [2:0] clk_out_b;
    logic [2:0] tick_b;

    int errors = 0;
    int checks = 0;

    clock_divider_multi_if #(.N_CH(4), .DIV_WIDTH(16)) cfg_a ();
    clock_divider_multi_if #(.N_CH(3), .DIV_WIDTH(16)) cfg_b ();

    clock_divider_multi #(
        .N_CH(4), .DIV_WIDTH(16), .DEFAULT_DIV(10)
    ) dut (
        .clk_in  (clk_in),
        .reset   (reset),
        .enable  (enable),
        .sync    (sync),
        .cfg     (cfg_a),
        .clk_out (clk_out),
        .tick    (tick)
    );

    clock_divider_multi #(
        .N_CH(3), .DIV_WIDTH(16), .DEFAULT_DIV(10)
    ) dut_b (
        .clk_in  (clk_in),
        .reset   (reset),
        .enable  (enable_b),
        .sync    (sync),
        .cfg     (cfg_b),
        .clk_out (clk_out_b),
        .tick    (tick_b)
    );

    always #5 clk_in = ~clk_in;

    task automatic step;
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        sync = 1'b0;
        enable = '0;
        cfg_a.cfg_valid = 1'b0;
        cfg_b.cfg_valid = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        enable = 4'hF;
        sync = 1'b1;
        cfg_a.cfg_valid = 1'b1;
        cfg_a.cfg_ch = 2'd0;
        cfg_a.cfg_div = 16'd0;
        reset = 1'b1;
        step();
        step();
        checks++;
        if (clk_out !== 4'h0) begin
            errors++;
            $display("FAIL rst_clk got=%h exp=0", clk_out);
        end
        checks++;
        if (tick !== 4'h0) begin
            errors++;
            $display("FAIL rst_tick got=%h exp=0", tick);
        end
        checks++;
        if (cfg_a.cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_err got=%b exp=0", cfg_a.cfg_err);
        end
        cfg_a.cfg_valid = 1'b0;
        sync = 1'b0;
        enable = '0;
        #1;
        checks++;
        if (cfg_a.cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready got=%b exp=1",
                     cfg_a.cfg_ready);
        end
        reset = 1'b0;
    endtask

    task automatic test_default;
        logic [3:0] ec, et;
        do_reset();
        enable = 4'hF;
        for (int k = 0; k < 20; k++) begin
            step();
            ec = ((k % 10) < 5) ? 4'hF : 4'h0;
            et = ((k % 10) == 0) ? 4'hF : 4'h0;
            checks++;
            if (clk_out !== ec) begin
                errors++;
                $display("FAIL def_clk k=%0d got=%h exp=%h",
                         k, clk_out, ec);
            end
            checks++;
            if (tick !== et) begin
                errors++;
                $display("FAIL def_tick k=%0d got=%h exp=%h",
                         k, tick, et);
            end
        end
    endtask

    task automatic test_cfg_update;
        logic e;
        do_reset();
        enable = 4'hF;
        step();
        step();
        step();
        cfg_a.cfg_valid = 1'b1;
        cfg_a.cfg_ch = 2'd1;
        cfg_a.cfg_div = 16'd5;
        #1;
        checks++;
        if (cfg_a.cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL upd_ready0 got=%b exp=1",
                     cfg_a.cfg_ready);
        end
        step();
        cfg_a.cfg_valid = 1'b0;
        #1;
        checks++;
        if (cfg_a.cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL upd_busy got=%b exp=0",
                     cfg_a.cfg_ready);
        end
        for (int k = 4; k < 10; k++) begin
            step();
            e = (k < 5);
            checks++;
            if (clk_out[1] !== e || cfg_a.cfg_ready !== 1'b0) begin
                errors++;
                $display("FAIL upd_old k=%0d got=%b/%b exp=%b/0",
                         k, clk_out[1], cfg_a.cfg_ready, e);
            end
        end
        step();
        checks++;
        if (tick[1] !== 1'b1 || clk_out[1] !== 1'b1) begin
            errors++;
            $display("FAIL upd_wrap got=%b/%b exp=1/1",
                     tick[1], clk_out[1]);
        end
        checks++;
        if (cfg_a.cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL upd_ready1 got=%b exp=1",
                     cfg_a.cfg_ready);
        end
        for (int j = 1; j < 15; j++) begin
            step();
            checks++;
            if (clk_out[1] !== ((j % 5) < 3) ||
                tick[1] !== ((j % 5) == 0)) begin
                errors++;
                $display("FAIL upd_new j=%0d got=%b/%b exp=%b/%b",
                         j, clk_out[1], tick[1],
                         (j % 5) < 3, (j % 5) == 0);
            end
            checks++;
            if (clk_out[0] !== ((j % 10) < 5)) begin
                errors++;
                $display("FAIL upd_ch0 j=%0d got=%b exp=%b",
                         j, clk_out[0], (j % 10) < 5);
            end
        end
    endtask

    task automatic test_err;
        do_reset();
        enable = 4'hF;
        step();
        cfg_a.cfg_valid = 1'b1;
        cfg_a.cfg_ch = 2'd2;
        cfg_a.cfg_div = 16'd1;
        #1;
        checks++;
        if (cfg_a.cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL err_ready0 got=%b exp=1",
                     cfg_a.cfg_ready);
        end
        step();
        cfg_a.cfg_valid = 1'b0;
        #1;
        checks++;
        if (cfg_a.cfg_err !== 1'b1 || cfg_a.cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL err_pulse got=%b/%b exp=1/1",
                     cfg_a.cfg_err, cfg_a.cfg_ready);
        end
        step();
        checks++;
        if (cfg_a.cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear got=%b exp=0", cfg_a.cfg_err);
        end
        for (int k = 3; k < 10; k++) step();
        checks++;
        if (tick[2] !== 1'b0) begin
            errors++;
            $display("FAIL err_notick got=%b exp=0", tick[2]);
        end
        step();
        checks++;
        if (tick[2] !== 1'b1 || clk_out[2] !== 1'b1) begin
            errors++;
            $display("FAIL err_div got=%b/%b exp=1/1",
                     tick[2], clk_out[2]);
        end
        cfg_b.cfg_valid = 1'b1;
        cfg_b.cfg_ch = 2'd3;
        cfg_b.cfg_div = 16'd5;
        #1;
        checks++;
        if (cfg_b.cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL errb_ready got=%b exp=1",
                     cfg_b.cfg_ready);
        end
        step();
        cfg_b.cfg_valid = 1'b0;
        checks++;
        if (cfg_b.cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL errb_pulse got=%b exp=1", cfg_b.cfg_err);
        end
        step();
        checks++;
        if (cfg_b.cfg_err !== 1'b0 || clk_out_b !== 3'b000) begin
            errors++;
            $display("FAIL errb_clear got=%b/%b exp=0/000",
                     cfg_b.cfg_err, clk_out_b);
        end
    endtask

    task automatic test_sync;
        do_reset();
        enable = 4'hF;
        step();
        cfg_a.cfg_valid = 1'b1;
        cfg_a.cfg_ch = 2'd0;
        cfg_a.cfg_div = 16'd4;
        step();
        cfg_a.cfg_ch = 2'd2;
        cfg_a.cfg_div = 16'd6;
        step();
        cfg_a.cfg_valid = 1'b0;
        for (int k = 3; k < 10; k++) step();
        step();
        checks++;
        if (tick[0] !== 1'b1 || tick[2] !== 1'b1) begin
            errors++;
            $display("FAIL sync_apply got=%b/%b exp=1/1",
                     tick[0], tick[2]);
        end
        step();
        step();
        step();
        checks++;
        if (clk_out[0] !== 1'b0 || clk_out[2] !== 1'b0) begin
            errors++;
            $display("FAIL sync_pre got=%b/%b exp=0/0",
                     clk_out[0], clk_out[2]);
        end
        sync = 1'b1;
        step();
        sync = 1'b0;
        checks++;
        if (tick !== 4'hF || clk_out !== 4'hF) begin
            errors++;
            $display("FAIL sync_edge got=%h/%h exp=f/f",
                     tick, clk_out);
        end
        for (int k = 1; k < 8; k++) begin
            step();
            checks++;
            if (clk_out[0] !== ((k % 4) < 2) ||
                clk_out[2] !== ((k % 6) < 3) ||
                tick[0] !== ((k % 4) == 0)) begin
                errors++;
                $display("FAIL sync_run k=%0d got=%b%b%b exp=%b%b%b",
                         k, clk_out[0], clk_out[2], tick[0],
                         (k % 4) < 2, (k % 6) < 3, (k % 4) == 0);
            end
        end
    endtask

    task automatic test_enable;
        do_reset();
        enable = 4'hF;
        for (int k = 0; k < 4; k++) step();
        enable = 4'b0111;
        for (int j = 1; j <= 7; j++) begin
            step();
            checks++;
            if (clk_out[3] !== 1'b0 || tick[3] !== 1'b0) begin
                errors++;
                $display("FAIL en_low j=%0d got=%b/%b exp=0/0",
                         j, clk_out[3], tick[3]);
            end
        end
        enable = 4'hF;
        step();
        checks++;
        if (tick[3] !== 1'b1 || clk_out[3] !== 1'b1 ||
            tick[0] !== 1'b0) begin
            errors++;
            $display("FAIL en_rise got=%b%b%b exp=110",
                     tick[3], clk_out[3], tick[0]);
        end
        for (int j = 1; j <= 10; j++) begin
            step();
            checks++;
            if (clk_out[3] !== ((j % 10) < 5) ||
                tick[3] !== (j == 10)) begin
                errors++;
                $display("FAIL en_run j=%0d got=%b/%b exp=%b/%b",
                         j, clk_out[3], tick[3],
                         (j % 10) < 5, j == 10);
            end
        end
    endtask

    task automatic test_reset_pending;
        do_reset();
        enable = 4'hF;
        step();
        cfg_a.cfg_valid = 1'b1;
        cfg_a.cfg_ch = 2'd0;
        cfg_a.cfg_div = 16'd4;
        step();
        cfg_a.cfg_valid = 1'b0;
        #1;
        checks++;
        if (cfg_a.cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL rp_pend got=%b exp=0", cfg_a.cfg_ready);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (cfg_a.cfg_ready !== 1'b1 || clk_out !== 4'h0 ||
            tick !== 4'h0) begin
            errors++;
            $display("FAIL rp_clear got=%b/%h/%h exp=1/0/0",
                     cfg_a.cfg_ready, clk_out, tick);
        end
        for (int k = 0; k <= 10; k++) begin
            step();
            checks++;
            if (clk_out[0] !== ((k % 10) < 5) ||
                tick[0] !== ((k % 10) == 0)) begin
                errors++;
                $display("FAIL rp_run k=%0d got=%b/%b exp=%b/%b",
                         k, clk_out[0], tick[0],
                         (k % 10) < 5, (k % 10) == 0);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        enable = '0;
        enable_b = '0;
        sync = 1'b0;
        cfg_a.cfg_valid = 1'b0;
        cfg_a.cfg_ch = '0;
        cfg_a.cfg_div = '0;
        cfg_b.cfg_valid = 1'b0;
        cfg_b.cfg_ch = '0;
        cfg_b.cfg_div = '0;
        test_reset();
        test_default();
        test_cfg_update();
        test_err();
        test_sync();
        test_enable();
        test_reset_pending();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/clock_divider_multi.md
CLOCK_DIVIDER_MULTI -- requirements
Module: clock_divider_multi

Interface
REQ-001 Parameter N_CH, default 4: number of independent divider channels, range 1..16.
REQ-002 Parameter DIV_WIDTH, default 16: width of each channel divisor and counter.
REQ-003 Parameter DEFAULT_DIV, default 10: divisor loaded into every channel at reset; legal range 2..2^DIV_WIDTH-1.
REQ-004 Port clk_in  input  1: single clock; all state SHALL update on its rising edge only.
REQ-005 Port reset  input  1: synchronous, active-high reset.
REQ-006 Port enable  input  N_CH: per-channel run enable.
REQ-007 Port sync  input  1: single-cycle pulse; restarts the period of every enabled channel.
REQ-008 Port cfg_valid  input  1: divisor update request.
REQ-009 Port cfg_ch  input  max(1,$clog2(N_CH)): target channel of the update.
REQ-010 Port cfg_div  input  DIV_WIDTH: requested divisor.
REQ-011 Port cfg_ready  output  1: update can be accepted this cycle.
REQ-012 Port cfg_err  output  1: registered one-cycle pulse flagging a rejected update.
REQ-013 Port clk_out  output  N_CH: per-channel divided clock, registered.
REQ-014 Port tick  output  N_CH: per-channel one-cycle strobe at period start, registered.

Function
REQ-015 Each channel SHALL hold div (active divisor), cnt (0..div-1), pend_div and pend_valid.
REQ-016 When enable[i]=1, cnt SHALL advance by 1 per clk_in edge and wrap from div-1 to 0, giving a period of exactly div clk_in cycles.
REQ-017 clk_out[i] SHALL be registered and SHALL be 1 when the new cnt is below H = div - (div>>1), otherwise 0, giving a high phase of ceil(div/2) cycles; div=4 gives 1100, div=5 gives 11100.
REQ-018 tick[i] SHALL be 1 for exactly the cycle in which the new cnt equals 0, coincident with the rising edge of clk_out[i].
REQ-019 When enable[i]=0, the next edge SHALL force clk_out[i]=0, force tick[i]=0 and set cnt=div-1, so that re-enabling starts a fresh period (clk_out=1, tick=1) on the first enabled edge.
REQ-020 cfg_ready SHALL be combinationally equal to ~pend_valid[cfg_ch], or 1 when cfg_ch >= N_CH.
REQ-021 An update SHALL be accepted on an edge where cfg_valid=1 and cfg_ready=1.
REQ-022 An accepted update with 2 <= cfg_div and cfg_ch < N_CH SHALL set pend_div=cfg_div and pend_valid=1.
REQ-023 An accepted update with cfg_div < 2 or cfg_ch >= N_CH SHALL be discarded, SHALL leave all channel state unchanged and SHALL pulse cfg_err for one cycle on the following cycle.
REQ-024 A pending update SHALL be applied (div <= pend_div, pend_valid <= 0) on the edge where the channel's new cnt is 0, so that the new period uses the new divisor and no truncated or stretched phase occurs.
REQ-025 If the channel is disabled, a pending update SHALL be applied on the next edge, with cnt <= pend_div-1.
REQ-026 On an edge with sync=1, every enabled channel SHALL take new cnt = 0 (clk_out=1, tick=1), applying any pending divisor; disabled channels SHALL ignore sync.
REQ-027 When sync=1 coincides with a natural wrap, the result SHALL be identical to the wrap alone, with a single tick.
REQ-028 An update accepted on the same edge a wrap occurs SHALL NOT take effect until the following wrap.
REQ-029 All arithmetic SHALL stay within DIV_WIDTH bits; H and div-1 SHALL NOT overflow for any legal div.

Reset
REQ-030 Reset SHALL have priority over enable, sync and cfg_valid.
REQ-031 On reset, for every channel: div=DEFAULT_DIV, cnt=DEFAULT_DIV-1, pend_valid=0, clk_out=0, tick=0; cfg_err SHALL be 0.
REQ-032 Reset asserted mid-period SHALL discard pending updates and the current phase, with no residual tick after reset deasserts.

Verification
REQ-033 Reset, then enable=all-ones with defaults -> first enabled edge gives clk_out=1 and tick=1 on all channels; period 10 with 5 cycles high, all channels phase-aligned.
REQ-034 cfg_div=5 to ch1 mid-period -> ch1 completes its current 10-cycle period, then runs pattern 11100; cfg_ready for ch1 is 0 from acceptance until the wrap.
REQ-035 cfg_div=1, and separately cfg_ch=N_CH -> cfg_err pulses for one cycle, divisors unchanged, cfg_ready remains 1.
REQ-036 ch0 div=4 and ch2 div=6 free-running, then a sync pulse -> both show tick=1 and clk_out=1 on the next edge, re-phased together.
REQ-037 enable[3] dropped for 7 cycles, then raised -> clk_out[3]=0 while low; a fresh full period starting with tick on the first enabled edge.
REQ-038 Reset asserted with a pending update on ch0 -> after release ch0 runs DEFAULT_DIV and cfg_ready=1.
